parking_meter: RTL

Time-base and billing stage that runs on the 1 Hz `time_clk`. It keeps the simulated hour of day and a day/night occupancy timer for every parking slot. When a departure is flagged, it captures the leaving slot's timers and computes the fee. It sits upstream of the segment/LCD view logic and downstream of the departure/payment control, replacing the inline time counters in the top level.

---
 rtl/parking_pkg.sv | 23 ++
 rtl/slot_timer.sv | 49 ++++
 rtl/parking_meter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking meter time-base and billing stage.
// Provides the billing FSM state type, the default day window and rates, and
// the widths of the per-slot day/night occupancy counters.
package parking_pkg;

  // Per-slot counter widths; both counters saturate at all-ones.
  localparam int unsigned DAY_W   = 6;
  localparam int unsigned NIGHT_W = 5;

  // Default billing window (inclusive hours) and rates in fee units per hour.
  localparam int unsigned DEF_HOURS      = 24;
  localparam int unsigned DEF_DAY_START  = 6;
  localparam int unsigned DEF_DAY_END    = 22;
  localparam int unsigned DEF_DAY_RATE   = 2;
  localparam int unsigned DEF_NIGHT_RATE = 1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StHold
  } meter_state_e;

endpackage

// File: rtl/slot_timer.sv
// Day/night occupancy timer for one parking slot.
// Ports:
//   clk       - time base (one edge per simulated hour)
//   rst       - asynchronous active-low reset
//   clr       - synchronous clear (slot empty or system powered down)
//   is_day    - current hour lies in the day billing window
//   day_cnt   - saturating count of day hours occupied
//   night_cnt - saturating count of night hours occupied
module slot_timer
  import parking_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               is_day,
  output logic [DAY_W-1:0]   day_cnt,
  output logic [NIGHT_W-1:0] night_cnt
);

  logic [DAY_W-1:0]   day_q, day_d;
  logic [NIGHT_W-1:0] night_q, night_d;

  always_comb begin
    day_d   = day_q;
    night_d = night_q;
    if (clr) begin
      day_d   = '0;
      night_d = '0;
    end else if (is_day) begin
      if (day_q != '1) day_d = day_q + 1'b1;
    end else begin
      if (night_q != '1) night_d = night_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      day_q   <= '0;
      night_q <= '0;
    end else begin
      day_q   <= day_d;
      night_q <= night_d;
    end
  end

  assign day_cnt   = day_q;
  assign night_cnt = night_q;

endmodule

// File: rtl/parking_meter.sv
// Time-base and billing stage on the 1 Hz time_clk. Keeps the hour of day and
// a day/night occupancy timer per slot; on a departure it snapshots the
// leaving slot's timers and computes the fee.
// Ports:
//   time_clk   - 1 Hz time base
//   rst        - asynchronous active-low reset
//   power      - system enable (foreign domain, synchronized here)
//   occupied   - per-slot occupancy, 1 = car present (synchronized here)
//   leave      - per-slot departure flags, held until paid (synchronized here)
//   hour       - current hour 0..HOURS-1
//   bill_day   - captured day hours of the leaving car
//   bill_night - captured night hours of the leaving car
//   fee        - computed fee, saturated to FEE_W bits
//   bill_valid - bill_* and fee are valid
//   busy       - billing FSM not idle
module parking_meter
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned HOURS      = DEF_HOURS,
  parameter int unsigned DAY_START  = DEF_DAY_START,
  parameter int unsigned DAY_END    = DEF_DAY_END,
  parameter int unsigned DAY_RATE   = DEF_DAY_RATE,
  parameter int unsigned NIGHT_RATE = DEF_NIGHT_RATE,
  parameter int unsigned FEE_W      = 10
) (
  input  logic                 time_clk,
  input  logic                 rst,
  input  logic                 power,
  input  logic [NUM_SLOTS-1:0] occupied,
  input  logic [NUM_SLOTS-1:0] leave,
  output logic [5:0]           hour,
  output logic [DAY_W-1:0]     bill_day,
  output logic [NIGHT_W-1:0]   bill_night,
  output logic [FEE_W-1:0]     fee,
  output logic                 bill_valid,
  output logic                 busy
);

  localparam int unsigned WideW     = FEE_W + 2;
  localparam logic [5:0]  HourLast  = 6'(HOURS - 1);
  localparam logic [5:0]  DayStartH = 6'(DAY_START);
  localparam logic [5:0]  DayEndH   = 6'(DAY_END);

  // Two-flop synchronizers for the asynchronous control inputs.
  logic                 power_meta_q, power_s;
  logic [NUM_SLOTS-1:0] occupied_meta_q, occupied_s;
  logic [NUM_SLOTS-1:0] leave_meta_q, leave_s;

  always_ff @(posedge time_clk or negedge rst) begin
    if (!rst) begin
      power_meta_q    <= 1'b0;
      power_s         <= 1'b0;
      occupied_meta_q <= '0;
      occupied_s      <= '0;
      leave_meta_q    <= '0;
      leave_s         <= '0;
    end else begin
      power_meta_q    <= power;
      power_s         <= power_meta_q;
      occupied_meta_q <= occupied;
      occupied_s      <= occupied_meta_q;
      leave_meta_q    <= leave;
      leave_s         <= leave_meta_q;
    end
  end

  // Hour counter.
  logic [5:0] hour_q, hour_d;

  always_comb begin
    hour_d = hour_q;
    if (!power_s)                hour_d = '0;
    else if (hour_q == HourLast) hour_d = '0;
    else                         hour_d = hour_q + 6'd1;
  end

  // Pre-update hour picks the counter that advances on this edge.
  logic is_day;
  assign is_day = (hour_q >= DayStartH) && (hour_q <= DayEndH);

  // Per-slot timers.
  logic [NUM_SLOTS-1:0] slot_clr;
  logic [DAY_W-1:0]     day_cnt   [NUM_SLOTS];
  logic [NIGHT_W-1:0]   night_cnt [NUM_SLOTS];

  assign slot_clr = {NUM_SLOTS{~power_s}} | ~occupied_s;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    slot_timer u_slot_timer (
      .clk      (time_clk),
      .rst      (rst),
      .clr      (slot_clr[g]),
      .is_day   (is_day),
      .day_cnt  (day_cnt[g]),
      .night_cnt(night_cnt[g])
    );
  end

  // Lowest-index departing slot wins: scan downwards so the last hit is lowest.
  logic [DAY_W-1:0]   sel_day;
  logic [NIGHT_W-1:0] sel_night;

  always_comb begin
    sel_day   = '0;
    sel_night = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (leave_s[i]) begin
        sel_day   = day_cnt[i];
        sel_night = night_cnt[i];
      end
    end
  end

  // Fee datapath, two guard bits wide, saturated on the way out.
  logic [WideW-1:0] fee_wide;
  logic [FEE_W-1:0] fee_sat;

  assign fee_wide = WideW'(bill_day) * WideW'(DAY_RATE)
                  + WideW'(bill_night) * WideW'(NIGHT_RATE);
  assign fee_sat  = (|fee_wide[WideW-1:FEE_W]) ? '1 : fee_wide[FEE_W-1:0];

  // Billing FSM.
  meter_state_e       state_q, state_d;
  logic [DAY_W-1:0]   bill_day_q, bill_day_d;
  logic [NIGHT_W-1:0] bill_night_q, bill_night_d;
  logic [FEE_W-1:0]   fee_q, fee_d;
  logic               bill_valid_q, bill_valid_d;

  always_comb begin
    state_d      = state_q;
    bill_day_d   = bill_day_q;
    bill_night_d = bill_night_q;
    fee_d        = fee_q;
    bill_valid_d = bill_valid_q;

    unique case (state_q)
      StIdle: begin
        if (|leave_s) begin
          bill_day_d   = sel_day;
          bill_night_d = sel_night;
          state_d      = StCalc;
        end
      end
      StCalc: begin
        fee_d        = fee_sat;
        bill_valid_d = 1'b1;
        state_d      = StHold;
      end
      StHold: begin
        // Only an all-clear leave releases the bill; other changes are ignored.
        if (!(|leave_s)) begin
          bill_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Power loss overrides every transition.
    if (!power_s) begin
      state_d      = StIdle;
      bill_day_d   = '0;
      bill_night_d = '0;
      fee_d        = '0;
      bill_valid_d = 1'b0;
    end
  end

  always_ff @(posedge time_clk or negedge rst) begin
    if (!rst) begin
      hour_q       <= '0;
      state_q      <= StIdle;
      bill_day_q   <= '0;
      bill_night_q <= '0;
      fee_q        <= '0;
      bill_valid_q <= 1'b0;
    end else begin
      hour_q       <= hour_d;
      state_q      <= state_d;
      bill_day_q   <= bill_day_d;
      bill_night_q <= bill_night_d;
      fee_q        <= fee_d;
      bill_valid_q <= bill_valid_d;
    end
  end

  assign hour       = hour_q;
  assign bill_day   = bill_day_q;
  assign bill_night = bill_night_q;
  assign fee        = fee_q;
  assign bill_valid = bill_valid_q;
  assign busy       = (state_q != StIdle);

endmodule
